// File: rtl/prog_clk_div.sv
// Runtime-programmable clock divider and tick generator. The divisor changes only
// on a rising period boundary, so every period it produces is whole and glitch-free.
module prog_clk_div #(
    parameter int WIDTH       = 17,
    parameter int DEFAULT_DIV = 100000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             sync_clr,
    input  logic [WIDTH-1:0] div_val,
    input  logic             div_load,
    output logic             clk_out,
    output logic             tick,
    output logic [WIDTH-1:0] cur_div,
    output logic             pending
);

    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);

    // A divisor of zero behaves as one: the output toggles every cycle.
    function automatic logic [WIDTH-1:0] eff(input logic [WIDTH-1:0] x);
        return (x == '0) ? ONE : x;
    endfunction

    // Counter reload value for a phase governed by divisor x.
    function automatic logic [WIDTH-1:0] reload(input logic [WIDTH-1:0] x);
        return eff(x) - ONE;
    endfunction

    localparam logic [WIDTH-1:0] DEF_CNT = (DEF_DIV == '0) ? '0 : (DEF_DIV - ONE);

    logic [WIDTH-1:0] cnt_q,     cnt_d;
    logic [WIDTH-1:0] cur_div_q, cur_div_d;
    logic [WIDTH-1:0] shadow_q,  shadow_d;
    logic             pending_q, pending_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q,    tick_d;

    logic             at_boundary;
    logic             rising_edge_due;
    logic [WIDTH-1:0] sync_div;

    assign at_boundary     = (cnt_q == '0);
    assign rising_edge_due = at_boundary && !clk_out_q;

    // Divisor that takes over on a phase restart; a same-cycle load overrides the shadow.
    always_comb begin
        sync_div = cur_div_q;
        if (pending_q) begin
            sync_div = shadow_q;
        end
        if (div_load) begin
            sync_div = div_val;
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        cur_div_d = cur_div_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        clk_out_d = clk_out_q;
        tick_d    = 1'b0;

        if (sync_clr) begin
            cur_div_d = sync_div;
            pending_d = 1'b0;
            cnt_d     = reload(sync_div);
            clk_out_d = 1'b0;
        end else if (!en) begin
            clk_out_d = 1'b0;
            cnt_d     = reload(cur_div_q);
            if (div_load) begin
                cur_div_d = div_val;
                pending_d = 1'b0;
                cnt_d     = reload(div_val);
            end
        end else if (!at_boundary) begin
            cnt_d = cnt_q - ONE;
            if (div_load) begin
                shadow_d  = div_val;
                pending_d = 1'b1;
            end
        end else begin
            clk_out_d = ~clk_out_q;
            if (rising_edge_due) begin
                tick_d = 1'b1;
                if (pending_q) begin
                    cur_div_d = shadow_q;
                    pending_d = 1'b0;
                    cnt_d     = reload(shadow_q);
                end else begin
                    cnt_d = reload(cur_div_q);
                end
            end else begin
                cnt_d = reload(cur_div_q);
            end
            // A load on the boundary waits for the next period; the old shadow was applied above.
            if (div_load) begin
                shadow_d  = div_val;
                pending_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= DEF_CNT;
            cur_div_q <= DEF_DIV;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            cur_div_q <= cur_div_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;
    assign cur_div = cur_div_q;
    assign pending = pending_q;

endmodule

// File: doc/prog_clk_div.md
Name: prog_clk_div

Overview:
Parametrised, runtime-programmable clock divider and tick generator. It generalises the fixed-ratio dividers to any width and any divisor loaded at run time. Divisor changes are glitch-free and take effect on period boundaries. It adds enable and phase-restart control, plus a one-cycle tick output. The block sits beside the fixed dividers and feeds slow-rate logic such as display refresh and game timers.

Parameters:
WIDTH, 17, bit width of the divisor and of the internal down-counter.
DEFAULT_DIV, 100000, half-period in clk cycles after reset; must fit in WIDTH bits.

Ports:
clk  input  1  system clock; every register updates on its rising edge
reset_n  input  1  asynchronous active-low reset
en  input  1  run enable
sync_clr  input  1  synchronous phase restart
div_val  input  WIDTH  requested half-period in clk cycles
div_load  input  1  one-cycle strobe that captures div_val
clk_out  output  1  divided square wave, registered
tick  output  1  one-cycle pulse on each rising edge of clk_out, registered
cur_div  output  WIDTH  half-period currently in force
pending  output  1  a loaded divisor is waiting for the next period boundary

Behaviour:
- Reset (reset_n=0, asynchronous):
  - clk_out=0, tick=0, pending=0.
  - cur_div=DEFAULT_DIV, shadow=0.
  - cnt=eff(DEFAULT_DIV)-1.
- eff(x) = 1 if x==0, else x. A divisor of 0 behaves as 1: toggle every cycle, period 2.
- Output period = 2*eff(cur_div) clk cycles, 50% duty.
- Priority each edge: reset > sync_clr > en=0 > run.
- sync_clr=1:
  - If pending, cur_div <= shadow and pending <= 0.
  - cnt <= eff(new cur_div)-1, clk_out <= 0, tick <= 0.
  - A div_load in the same cycle is applied directly: cur_div <= div_val, pending <= 0.
- en=0 (idle):
  - cnt <= eff(cur_div)-1, clk_out <= 0, tick <= 0.
  - div_load applies immediately: cur_div <= div_val, cnt <= eff(div_val)-1, pending stays 0.
- en=1, cnt!=0 (run):
  - cnt <= cnt-1, tick <= 0.
  - div_load: shadow <= div_val, pending <= 1. Last load wins.
- en=1, cnt==0 (boundary):
  - clk_out <= ~clk_out.
  - Rising boundary (clk_out was 0):
    - tick <= 1.
    - If pending: cur_div <= shadow, pending <= 0, cnt <= eff(shadow)-1.
    - Otherwise cnt <= eff(cur_div)-1.
  - Falling boundary (clk_out was 1): tick <= 0, cnt <= eff(cur_div)-1.
  - The new divisor therefore governs whole periods, starting with the high phase; no partial-phase glitch.
  - div_load on a boundary cycle: shadow <= div_val and pending <= 1. The value applied on that edge is the previous shadow, if one was pending.
- Latency:
  - The first edge with en=1 starts the count.
  - clk_out rises after eff(cur_div) enabled edges and tick is high in that same cycle.
  - Dropping en returns clk_out to 0 on the next edge.
- tick is never high for two consecutive cycles, except when eff(cur_div)=1, where it pulses every other cycle.
- Counter arithmetic is unsigned, WIDTH bits, down-count only. cnt never wraps below 0 because it is reloaded at 0.

Test Plan:
- Reset default: DEFAULT_DIV=3, en=1 after reset -> clk_out 0 for 3 cycles, 1 for 3, period 6; tick high exactly in each first high cycle; cur_div=3.
- Divisor 0/1: idle load div_val=0, then en=1 -> clk_out toggles every cycle, tick every 2nd cycle; repeat with 1 -> identical waveform.
- Glitch-free change:
  - Running at 4, pulse div_load with 2 mid-high-phase -> pending=1.
  - Current period completes at 4/4; the next high phase lasts 2 cycles; pending clears on that rising edge; cur_div=2.
- Last-load-wins and boundary load:
  - Running at 5, load 7 then 3 in the same period -> next period uses 3.
  - A load of 6 exactly on a rising-boundary cycle -> pending stays 1 and 6 is used from the following period.
- sync_clr mid-high-phase with pending=1 (shadow 2) -> next cycle clk_out=0, cur_div=2, pending=0, then rise after 2 cycles.
- en drop and async reset:
  - Deassert en while clk_out=1 -> clk_out=0 next edge, tick=0.
  - Reassert en -> rise after eff(cur_div) cycles.
  - Assert reset_n=0 between clock edges -> outputs clear immediately without waiting for clk.
